dma_channel_arbiter: RTL
========================

# dma_channel_arbiter

Four-channel request arbiter and bus-hold sequencer for the 8237A-style DMA controller. It conditions raw DREQ pins for polarity and masking, merges software requests, and raises HRQ to the CPU. On HLDA it grants exactly one channel by fixed or rotating priority, drives DACK with programmable polarity, and rotates priority when service completes. It sits between the command/mask/request registers and the transfer timing FSM, which reports end of service on `cycleDone`.

## Interface
- `NUM_CH`, 4: channel count. Only 4 is supported.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-low reset.
- `dreq`  in  4  raw DREQ pins, polarity set by `dreqSense`.
- `dreqSense`  in  1  command bit 6: 0 = DREQ active-high, 1 = active-low.
- `dackSense`  in  1  command bit 7: 0 = DACK active-low, 1 = active-high.
- `rotatePri`  in  1  command bit 4: 0 = fixed priority, 1 = rotating.
- `ctrlDisable`  in  1  command bit 2: 1 blocks new arbitration.
- `mask`  in  4  mask register; 1 masks the hardware DREQ of that channel.
- `softReq`  in  4  request register bits; not maskable.
- `hlda`  in  1  hold acknowledge from the CPU.
- `cycleDone`  in  1  one-cycle pulse from the timing FSM at end of service (TC, EOP or single transfer).
- `hrq`  out  1  hold request.
- `dack`  out  4  DACK pins, polarity applied.
- `grantValid`  out  1  a channel is currently granted.
- `activeCh`  out  2  index of the granted channel.
- `chPriority`  out  8  {pri3,pri2,pri1,pri0}; 0 is the highest priority.

## Operation
- DREQ conditioning:
  - `dreqQ <= dreq ^ {4{dreqSense}}` is registered every cycle.
  - `valid = (dreqQ & ~mask) | softReq`.
  - A request is pending when `|valid && !ctrlDisable`.
- Priority state is a 2-bit pointer `topCh`. The priority of channel i is `(i - topCh) mod 4`. The winner is the valid channel with the lowest priority value.
- FSM states are IDLE, REQ, GRANT and RELEASE:
  - **IDLE:** `hrq`=0. If a request is pending, go to REQ.
  - **REQ:** `hrq`=1.
    - If no request is pending, go to IDLE; this takes precedence over `hlda`.
    - Otherwise, if `hlda`=1, latch the winner into `activeCh`, set the one-hot `dackInt`, and go to GRANT.
  - **GRANT:** `hrq`=1, `grantValid`=1.
    - If `hlda`=0, abort: clear `dackInt`, do not rotate, go to IDLE.
    - Else, if `cycleDone`=1, go to RELEASE.
    - Changes to `mask`, `dreq` and `ctrlDisable` do not affect the current grant.
  - **RELEASE:** `hrq`=0, `dackInt`=0. If `rotatePri`=1, `topCh <= activeCh + 1` (mod 4). Always go to IDLE.
- `dack = dackInt ^ {4{~dackSense}}`. This is the only combinational output path.
- In fixed mode, `topCh` is forced to 0 on every cycle in which `rotatePri`=0.
- Reset values:
  - Internal state: IDLE; `topCh`=0; `dackInt`=0; `dreqQ`=0.
  - Outputs: `hrq`=0; `grantValid`=0; `activeCh`=0; `chPriority`=8'hE4; `dack`=4'b1111 (with `dackSense`=0).
- A reset asserted in any state, including GRANT, takes effect on the next edge and performs no rotation.

## Timing
- `dreq` changes before edge N, so `dreqQ` is valid after N. At edge N+1 the FSM enters REQ, so `hrq` is high after N+1. Minimum DREQ→HRQ latency is 2 cycles.
- `hlda` sampled high at edge M → `dack`/`grantValid` active after M. HLDA→DACK latency is 1 cycle.
- `cycleDone` sampled at edge P → `dack` inactive, `hrq` low and `grantValid` low after P. The FSM is in IDLE after P+1.
- The earliest re-request raises `hrq` after P+2. This guarantees at least 2 cycles with `hrq` low between grants.
- `cycleDone` outside GRANT is ignored. `hlda` outside REQ/GRANT is ignored.
- `chPriority` reflects `topCh` registered and updates on the edge that leaves RELEASE.

## Structure
- `dma_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} arbState_t`.
  - `NUM_CH = 4`.
  - `CH_PRIORITY_RESET = 8'hE4`.
- Sub-module `dma_priority_encoder`: combinational. Inputs are `valid[3:0]` and `topCh[1:0]`; outputs are `winner[1:0]` and `any`. It also computes `chPriority`.
- All other logic (sync register, FSM, pointer, DACK polarity) lives in `dma_channel_arbiter`.

## Test plan
1. **Reset:** hold `RESET`=0 for 2 cycles with `dreq`=4'hF → `hrq`=0, `dack`=4'b1111, `grantValid`=0, `chPriority`=8'hE4.
2. **Fixed priority:** `rotatePri`=0, `dreq`=4'b1010, `hlda` rises 3 cycles after `hrq` → `dack`=4'b1101, `activeCh`=1. Pulse `cycleDone` → `hrq` low for 2 cycles, then ch3 is granted with `dack`=4'b0111.
3. **Rotation:** `rotatePri`=1, service ch1 → `chPriority`=8'h4E (ch2=0, ch3=1, ch0=2, ch1=3). Then `dreq`=4'b0011 → ch0 is granted.
4. **Mask / software request:**
   - `mask`=4'b0001, `dreq`=4'b0001 → `hrq` stays 0 for 10 cycles.
   - Set `softReq`=4'b0001 → `hrq` rises 1 cycle later. With `hlda`=1, ch0 is granted.
5. **Withdrawal and abort:**
   - Drop `dreq` while in REQ → `hrq` falls next cycle and `dack` is never asserted.
   - Drop `hlda` in GRANT → `dack` goes inactive next cycle and `chPriority` is unchanged.
6. **Polarity and reset mid-grant:**
   - `dreqSense`=1, `dackSense`=1, `dreq`=4'b1011 → ch2 is granted with `dack`=4'b0100.
   - Assert `RESET`=0 during GRANT → `dack`=4'b0000, `hrq`=0 after the next edge, and `topCh` returns to 0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the four-channel DMA request arbiter.
// Imported by the arbiter top and by the priority encoder.
package dma_pkg;

  localparam int         NUM_CH            = 4;
  localparam logic [7:0] CH_PRIORITY_RESET = 8'hE4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arbState_t;

  // One-hot DACK pattern for a channel index.
  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    ch_onehot = 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Request/grant bundle between the DMA register file, the CPU hold
// handshake and the channel arbiter; the arbiter uses the slave side.
interface dma_channel_arbiter_if;

  logic [3:0] dreq;
  logic       dreqSense;
  logic       dackSense;
  logic       rotatePri;
  logic       ctrlDisable;
  logic [3:0] mask;
  logic [3:0] softReq;
  logic       hlda;
  logic       cycleDone;
  logic       hrq;
  logic [3:0] dack;
  logic       grantValid;
  logic [1:0] activeCh;
  logic [7:0] chPriority;

  modport master (
    output dreq, dreqSense, dackSense, rotatePri, ctrlDisable,
    output mask, softReq, hlda, cycleDone,
    input  hrq, dack, grantValid, activeCh, chPriority
  );

  modport slave (
    input  dreq, dreqSense, dackSense, rotatePri, ctrlDisable,
    input  mask, softReq, hlda, cycleDone,
    output hrq, dack, grantValid, activeCh, chPriority
  );

endinterface

// File: rtl/dma_priority_encoder.sv
// Combinational channel selector: picks the valid channel closest to the
// rotating top pointer and reports the resulting per-channel priorities.
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [3:0] valid,
  input  logic [1:0] topCh,
  output logic [1:0] winner,
  output logic       any,
  output logic [7:0] chPriority
);

  logic [1:0] idx_s;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    winner = 2'd0;
    any    = 1'b0;
    idx_s  = 2'd0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx_s = topCh + 2'(k);
      if (valid[idx_s]) begin
        winner = idx_s;
        any    = 1'b1;
      end else begin
        any    = any;
      end
    end
  end

  // Priority of channel i is its distance from the top pointer.
  always_comb begin
    chPriority = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      chPriority[2*i +: 2] = 2'(i) - topCh;
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DREQ conditioning, HRQ/HLDA bus-hold sequencing and DACK generation for
// four DMA channels with fixed or rotating priority.
module dma_channel_arbiter
  import dma_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  dma_channel_arbiter_if.slave  bus
);

  arbState_t  state_r;
  arbState_t  next_state_s;
  logic [3:0] dreq_q_r;
  logic [3:0] valid_s;
  logic [3:0] dack_int_r;
  logic [1:0] top_ch_r;
  logic [1:0] active_ch_r;
  logic [1:0] winner_s;
  logic       any_s;
  logic       pending_s;
  logic       hrq_s;
  logic       grant_valid_s;
  logic [7:0] ch_priority_s;

  // Polarity-normalised DREQ sampled once per cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      dreq_q_r <= 4'b0000;
    end else begin
      dreq_q_r <= bus.dreq ^ {4{bus.dreqSense}};
    end
  end

  // Software requests bypass the mask register.
  assign valid_s   = (dreq_q_r & ~bus.mask) | bus.softReq;
  assign pending_s = any_s & ~bus.ctrlDisable;

  dma_priority_encoder u_pri (
    .valid      (valid_s),
    .topCh      (top_ch_r),
    .winner     (winner_s),
    .any        (any_s),
    .chPriority (ch_priority_s)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; a withdrawn request beats a late HLDA in REQ.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pending_s) next_state_s = REQ;
        else           next_state_s = IDLE;
      end
      REQ: begin
        if (!pending_s)    next_state_s = IDLE;
        else if (bus.hlda) next_state_s = GRANT;
        else               next_state_s = REQ;
      end
      GRANT: begin
        if (!bus.hlda)          next_state_s = IDLE;
        else if (bus.cycleDone) next_state_s = RELEASE;
        else                    next_state_s = GRANT;
      end
      RELEASE: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    hrq_s         = 1'b0;
    grant_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        hrq_s         = 1'b0;
        grant_valid_s = 1'b0;
      end
      REQ: begin
        hrq_s         = 1'b1;
        grant_valid_s = 1'b0;
      end
      GRANT: begin
        hrq_s         = 1'b1;
        grant_valid_s = 1'b1;
      end
      RELEASE: begin
        hrq_s         = 1'b0;
        grant_valid_s = 1'b0;
      end
      default: begin
        hrq_s         = 1'b0;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  // Grant latch: channel frozen on HLDA, DACK dropped whenever GRANT is left.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      active_ch_r <= 2'd0;
      dack_int_r  <= 4'b0000;
    end else if ((state_r == REQ) && (next_state_s == GRANT)) begin
      active_ch_r <= winner_s;
      dack_int_r  <= ch_onehot(winner_s);
    end else if (next_state_s != GRANT) begin
      active_ch_r <= active_ch_r;
      dack_int_r  <= 4'b0000;
    end else begin
      active_ch_r <= active_ch_r;
      dack_int_r  <= dack_int_r;
    end
  end

  // Priority pointer: pinned to 0 in fixed mode, advances past the served channel.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      top_ch_r <= 2'd0;
    end else if (!bus.rotatePri) begin
      top_ch_r <= 2'd0;
    end else if (state_r == RELEASE) begin
      top_ch_r <= active_ch_r + 2'd1;
    end else begin
      top_ch_r <= top_ch_r;
    end
  end

  assign bus.hrq        = hrq_s;
  assign bus.grantValid = grant_valid_s;
  assign bus.activeCh   = active_ch_r;
  assign bus.chPriority = ch_priority_s;
  assign bus.dack       = dack_int_r ^ {4{~bus.dackSense}};

endmodule
